// File: rtl/tft_arbiter.sv
// tft_arbiter: round-robin owner of the shared TFT byte interface; an owner keeps
// the bus for a whole transaction and the last byte drains before handover.
module tft_arbiter #(
    parameter int N_REQ = 3,
    parameter int IDX_W = $clog2(N_REQ)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [N_REQ-1:0]   req,
    input  logic [N_REQ-1:0]   rq_transmit,
    input  logic [N_REQ-1:0]   rq_dc,
    input  logic [8*N_REQ-1:0] rq_data,
    output logic [N_REQ-1:0]   gnt,
    output logic [N_REQ-1:0]   rq_busy,
    input  logic               tft_busy,
    output logic               tft_transmit,
    output logic               tft_dc,
    output logic [7:0]         tft_data,
    output logic [IDX_W-1:0]   owner,
    output logic               protocol_err
);
    typedef enum logic [1:0] {IDLE, OWNED, DRAIN} state_t;
    state_t state, state_nx;
    logic [IDX_W-1:0] winner, idx;
    logic found, accept;
    // search starts just after the last owner, so it becomes lowest priority
    always_comb begin
        winner = owner;
        idx = owner;
        found = 1'b0;
        for (int k = 1; k <= N_REQ; k++) begin
            idx = IDX_W'((int'(owner) + k) % N_REQ);
            if (!found && req[idx]) begin
                found = 1'b1;
                winner = idx;
            end
        end
    end
    always_comb begin
        gnt = '0;
        rq_busy = '1;
        if (state != IDLE) gnt[owner] = 1'b1;
        if (state == OWNED) rq_busy[owner] = tft_busy | tft_transmit;
    end
    assign accept = (state == OWNED) && rq_transmit[owner] && !rq_busy[owner];
    always_comb begin
        state_nx = state;
        if (state == IDLE && found) state_nx = OWNED;
        else if (state == OWNED && !req[owner]) state_nx = DRAIN;
        else if (state == DRAIN && !tft_transmit && !tft_busy) state_nx = IDLE;
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else state <= state_nx;
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            owner <= IDX_W'(N_REQ - 1);
            tft_transmit <= 1'b0;
            tft_dc <= 1'b0;
            tft_data <= 8'h00;
            protocol_err <= 1'b0;
        end else begin
            if (state == IDLE && found) owner <= winner;
            tft_transmit <= accept;
            if (accept) begin
                tft_dc <= rq_dc[owner];
                tft_data <= rq_data[{owner, 3'b000} +: 8];
            end
            if (|(rq_transmit & rq_busy)) protocol_err <= 1'b1;
        end
    end
endmodule

// File: tb/tb_tft_arbiter.sv
// tb_tft_arbiter: directed scenarios for tft_arbiter with N_REQ=3; inputs change
// and outputs are sampled on the falling clock edge.
module tb_tft_arbiter;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [2:0]  req = '0, rq_transmit = '0, rq_dc = '0;
    logic [23:0] rq_data = '0;
    logic [2:0]  gnt, rq_busy;
    logic        tft_busy = 1'b0;
    logic        tft_transmit, tft_dc, protocol_err;
    logic [7:0]  tft_data;
    logic [1:0]  owner;
    int checks = 0, errors = 0;

    tft_arbiter #(.N_REQ(3)) dut (
        .clk(clk), .rst(rst), .req(req), .rq_transmit(rq_transmit), .rq_dc(rq_dc),
        .rq_data(rq_data), .gnt(gnt), .rq_busy(rq_busy), .tft_busy(tft_busy),
        .tft_transmit(tft_transmit), .tft_dc(tft_dc), .tft_data(tft_data),
        .owner(owner), .protocol_err(protocol_err)
    );

    always #5 clk = ~clk;

    task automatic do_reset();
        req = '0; rq_transmit = '0; rq_dc = '0; rq_data = '0; tft_busy = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if ({gnt, tft_transmit, tft_dc, tft_data, protocol_err} !== 13'h0) begin
            errors++; $display("FAIL reset_outputs: got gnt=%b tx=%b dc=%b data=%h err=%b required all 0", gnt, tft_transmit, tft_dc, tft_data, protocol_err);
        end
        checks++;
        if (owner !== 2'd2) begin errors++; $display("FAIL reset_owner: got %0d required 2", owner); end
        checks++;
        if (rq_busy !== 3'b111) begin errors++; $display("FAIL reset_busy: got %b required 111", rq_busy); end
        rst = 1'b0;
    endtask

    task automatic test_single();
        logic [7:0] bytes [3] = '{8'h2A, 8'h00, 8'h05};
        logic       dcs   [3] = '{1'b0, 1'b1, 1'b1};
        req = 3'b001;
        @(negedge clk);
        checks++;
        if (gnt !== 3'b001 || owner !== 2'd0) begin errors++; $display("FAIL single_grant: got gnt=%b owner=%0d required 001/0", gnt, owner); end
        checks++;
        if (rq_busy !== 3'b110) begin errors++; $display("FAIL single_busy: got %b required 110", rq_busy); end
        for (int i = 0; i < 3; i++) begin
            rq_transmit = 3'b001; rq_dc[0] = dcs[i]; rq_data[7:0] = bytes[i];
            @(negedge clk);
            rq_transmit = '0;
            checks++;
            if (tft_transmit !== 1'b1 || tft_data !== bytes[i] || tft_dc !== dcs[i]) begin
                errors++; $display("FAIL single_byte%0d: got tx=%b dc=%b data=%h required 1/%b/%h", i, tft_transmit, tft_dc, tft_data, dcs[i], bytes[i]);
            end
            @(negedge clk);
            checks++;
            if (tft_transmit !== 1'b0 || tft_data !== bytes[i]) begin
                errors++; $display("FAIL single_pulse%0d: got tx=%b data=%h required 0/%h", i, tft_transmit, tft_data, bytes[i]);
            end
        end
        req = '0;
        @(negedge clk);
        checks++;
        if (gnt !== 3'b001) begin errors++; $display("FAIL single_drain: got gnt=%b required 001", gnt); end
        @(negedge clk);
        checks++;
        if (gnt !== 3'b000) begin errors++; $display("FAIL single_idle: got gnt=%b required 000", gnt); end
    endtask

    task automatic test_round_robin();
        int order [4] = '{0, 1, 2, 0};
        int waited;
        do_reset();
        req = 3'b111;
        for (int i = 0; i < 4; i++) begin
            waited = 0;
            while (gnt === 3'b000 && waited < 20) begin @(negedge clk); waited++; end
            checks++;
            if (gnt !== 3'(1 << order[i]) || owner !== 2'(order[i]) || waited < 1) begin
                errors++; $display("FAIL rr_grant%0d: got gnt=%b owner=%0d idle=%0d required owner %0d idle>=1", i, gnt, owner, waited, order[i]);
            end
            rq_transmit[order[i]] = 1'b1; rq_dc[order[i]] = 1'b1;
            rq_data[8*order[i] +: 8] = 8'h10 + 8'(order[i]);
            @(negedge clk);
            rq_transmit = '0; req[order[i]] = 1'b0;
            checks++;
            if (tft_transmit !== 1'b1 || tft_data !== 8'h10 + 8'(order[i])) begin
                errors++; $display("FAIL rr_byte%0d: got tx=%b data=%h required 1/%h", i, tft_transmit, tft_data, 8'h10 + 8'(order[i]));
            end
            @(negedge clk);
            checks++;
            if (gnt !== 3'(1 << order[i])) begin errors++; $display("FAIL rr_hold%0d: got gnt=%b", i, gnt); end
            @(negedge clk);
            req[order[i]] = 1'b1;
        end
        req = '0;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_drain_busy();
        int held = 0;
        req = 3'b010;
        @(negedge clk);
        checks++;
        if (gnt !== 3'b010) begin errors++; $display("FAIL drain_grant: got gnt=%b required 010", gnt); end
        tft_busy = 1'b1; req = 3'b101;
        repeat (10) begin
            @(negedge clk);
            if (gnt === 3'b010) held++;
        end
        checks++;
        if (held !== 10) begin errors++; $display("FAIL drain_hold: gnt held %0d cycles required 10", held); end
        tft_busy = 1'b0;
        @(negedge clk);
        checks++;
        if (gnt !== 3'b000) begin errors++; $display("FAIL drain_release: got gnt=%b required 000", gnt); end
        @(negedge clk);
        checks++;
        if (gnt !== 3'b100 || owner !== 2'd2) begin errors++; $display("FAIL drain_next: got gnt=%b owner=%0d required 100/2", gnt, owner); end
        req = '0;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_protocol_err();
        do_reset();
        req = 3'b001;
        @(negedge clk);
        tft_busy = 1'b1; rq_transmit = 3'b001; rq_data[7:0] = 8'hEE;
        @(negedge clk);
        rq_transmit = '0; tft_busy = 1'b0;
        checks++;
        if (tft_transmit !== 1'b0 || protocol_err !== 1'b1 || tft_data !== 8'h00) begin
            errors++; $display("FAIL err_owner_busy: got tx=%b err=%b data=%h required 0/1/00", tft_transmit, protocol_err, tft_data);
        end
        do_reset();
        checks++;
        if (protocol_err !== 1'b0) begin errors++; $display("FAIL err_clear: got %b required 0", protocol_err); end
        req = 3'b001;
        @(negedge clk);
        rq_transmit = 3'b100; rq_data[23:16] = 8'h77;
        @(negedge clk);
        rq_transmit = '0;
        checks++;
        if (tft_transmit !== 1'b0 || protocol_err !== 1'b1) begin
            errors++; $display("FAIL err_nonowner: got tx=%b err=%b required 0/1", tft_transmit, protocol_err);
        end
        repeat (3) @(negedge clk);
        checks++;
        if (protocol_err !== 1'b1 || tft_data === 8'h77) begin errors++; $display("FAIL err_sticky: got err=%b data=%h required 1/not 77", protocol_err, tft_data); end
        req = '0;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_async_reset();
        do_reset();
        req = 3'b001;
        @(negedge clk);
        rq_transmit = 3'b001; rq_dc[0] = 1'b1; rq_data[7:0] = 8'h5A;
        @(negedge clk);
        rq_transmit = '0;
        checks++;
        if (tft_transmit !== 1'b1 || tft_data !== 8'h5A) begin errors++; $display("FAIL async_pre: got tx=%b data=%h required 1/5A", tft_transmit, tft_data); end
        #1 rst = 1'b1;
        #1;
        checks++;
        if ({gnt, tft_transmit, tft_dc, tft_data, protocol_err} !== 13'h0 || owner !== 2'd2) begin
            errors++; $display("FAIL async_reset: got gnt=%b tx=%b dc=%b data=%h err=%b owner=%0d required zeros/2", gnt, tft_transmit, tft_dc, tft_data, protocol_err, owner);
        end
        req = '0;
        @(negedge clk);
        rst = 1'b0; req = 3'b010;
        @(negedge clk);
        checks++;
        if (gnt !== 3'b010 || owner !== 2'd1) begin errors++; $display("FAIL async_regrant: got gnt=%b owner=%0d required 010/1", gnt, owner); end
    endtask

    task automatic test_strobe_with_drop();
        rq_transmit = 3'b010; rq_dc[1] = 1'b1; rq_data[15:8] = 8'hC3; req = '0;
        @(negedge clk);
        rq_transmit = '0;
        checks++;
        if (tft_transmit !== 1'b1 || tft_dc !== 1'b1 || tft_data !== 8'hC3 || gnt !== 3'b010) begin
            errors++; $display("FAIL drop_byte: got tx=%b dc=%b data=%h gnt=%b required 1/1/C3/010", tft_transmit, tft_dc, tft_data, gnt);
        end
        @(negedge clk);
        checks++;
        if (gnt !== 3'b010 || tft_transmit !== 1'b0) begin errors++; $display("FAIL drop_drain: got gnt=%b tx=%b required 010/0", gnt, tft_transmit); end
        @(negedge clk);
        checks++;
        if (gnt !== 3'b000 || tft_data !== 8'hC3) begin errors++; $display("FAIL drop_idle: got gnt=%b data=%h required 000/C3", gnt, tft_data); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_drain_busy();
        test_protocol_err();
        test_async_reset();
        test_strobe_with_drop();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
